// File: rtl/toast_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | toast_pkg: shared RV32I encodings, ALU/state types and helpers        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package toast_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM} state_t;

  // alt is instr[30]; it only selects SUB for register-register ops
  function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    case (f3)
      F3_ADD_SUB: return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SR:      return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $signed(a) >>> sh;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/toast_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | toast_fetch: PC-driven instruction address and IF_Instruction latch   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module toast_fetch
  import toast_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  state_t      state,
  input  logic [31:0] pc,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_Instruction
);

  assign imem_addr = reset ? RESET_PC : pc;

  always_ff @(posedge clk) begin
    if (reset)
      IF_Instruction <= NOP;
    else if (state == S_DECODE)
      IF_Instruction <= imem_data;
  end

endmodule
`default_nettype wire

// File: rtl/toast_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | toast_core: multi-cycle RV32I core, one instruction in flight         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module toast_core
  import toast_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IMEM_data,
  input  logic [31:0] DMEM_rd_data,
  output logic [31:0] IMEM_addr,
  output logic [31:0] DMEM_addr,
  output logic [31:0] DMEM_wr_data,
  output logic        DMEM_wr_en,
  output logic        DMEM_rst
);

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] regs [32];
  logic [31:0] instr;

  toast_fetch #(.RESET_PC(RESET_PC)) IF_inst (
    .clk(Clk), .reset(Reset), .state(state), .pc(pc), .imem_data(IMEM_data),
    .imem_addr(IMEM_addr), .IF_Instruction(instr)
  );

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'b0};
  assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_y, ea;
  assign alu_op = decode_alu(funct3, instr[30], opcode == OP);
  assign alu_b  = (opcode == OP) ? rs2_val : imm_i;
  assign alu_y  = alu(alu_op, rs1_val, alu_b);
  assign ea     = rs1_val + ((opcode == STORE) ? imm_s : imm_i);

  logic        wb_en, mem_op;
  logic [31:0] wb_val, pc_next;
  always_comb begin
    wb_en   = 1'b0;
    wb_val  = alu_y;
    pc_next = pc + 32'd4;
    mem_op  = 1'b0;
    case (opcode)
      OP, OP_IMM: wb_en = 1'b1;
      LUI:    begin wb_en = 1'b1; wb_val = imm_u;      end
      AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
      JAL:    begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_next = pc + imm_j; end
      JALR:   begin
        wb_en   = 1'b1;
        wb_val  = pc + 32'd4;
        pc_next = (rs1_val + imm_i) & ~32'd1;
      end
      BRANCH: if (branch_taken(funct3, rs1_val, rs2_val)) pc_next = pc + imm_b;
      LOAD, STORE: mem_op = 1'b1;
      default: ;  // MISC_MEM, SYSTEM and illegal encodings retire as NOP
    endcase
  end

  logic [31:0] mem_ea, mem_rs2;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic        mem_store;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val, store_val;

  // Sub-word stores are read-modify-write against the word fetched in S_EXEC
  always_comb begin
    lane_byte = DMEM_rd_data[{mem_ea[1:0], 3'b000} +: 8];
    lane_half = mem_ea[1] ? DMEM_rd_data[31:16] : DMEM_rd_data[15:0];
    case (mem_funct3)
      F3_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_val = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_val = {24'b0, lane_byte};
      F3_LHU:  load_val = {16'b0, lane_half};
      default: load_val = DMEM_rd_data;
    endcase
    store_val = DMEM_rd_data;
    case (mem_funct3[1:0])
      2'b00:   store_val[{mem_ea[1:0], 3'b000} +: 8] = mem_rs2[7:0];
      2'b01:   store_val[{mem_ea[1], 4'b0000} +: 16] = mem_rs2[15:0];
      default: store_val = mem_rs2;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = mem_op ? S_MEM : S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    DMEM_addr    = 32'd0;
    DMEM_wr_data = 32'd0;
    DMEM_wr_en   = 1'b0;
    DMEM_rst     = 1'b1;
    if (!Reset) begin
      if (state == S_EXEC && mem_op) begin
        DMEM_addr = {ea[31:2], 2'b00};
        DMEM_rst  = 1'b0;
      end else if (state == S_MEM) begin
        DMEM_addr = {mem_ea[31:2], 2'b00};
        DMEM_rst  = 1'b0;
        if (mem_store) begin
          DMEM_wr_en   = 1'b1;
          DMEM_wr_data = store_val;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      mem_ea     <= 32'd0;
      mem_rs2    <= 32'd0;
      mem_funct3 <= 3'd0;
      mem_rd     <= 5'd0;
      mem_store  <= 1'b0;
    end else begin
      case (state)
        S_EXEC: begin
          if (mem_op) begin
            mem_ea     <= ea;
            mem_rs2    <= rs2_val;
            mem_funct3 <= funct3;
            mem_rd     <= rd;
            mem_store  <= (opcode == STORE);
          end else begin
            if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
            pc <= pc_next;
          end
        end
        S_MEM: begin
          if (!mem_store && mem_rd != 5'd0) regs[mem_rd] <= load_val;
          pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_toast_core.sv
`default_nettype none
// Directed-program bench for toast_core: an instruction-level model predicts
// every bus cycle and the final register file; literal checks pin the model.
module tb_toast_core;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IMEM_data, DMEM_rd_data, IMEM_addr, DMEM_addr, DMEM_wr_data;
  logic        DMEM_wr_en, DMEM_rst;

  toast_core #(.RESET_PC(32'h0)) dut (
    .Clk(Clk), .Reset(Reset), .IMEM_data(IMEM_data), .DMEM_rd_data(DMEM_rd_data),
    .IMEM_addr(IMEM_addr), .DMEM_addr(DMEM_addr), .DMEM_wr_data(DMEM_wr_data),
    .DMEM_wr_en(DMEM_wr_en), .DMEM_rst(DMEM_rst)
  );

  always #5 Clk = ~Clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic        dmem_clear = 1'b0;

  always @(posedge Clk) begin
    IMEM_data <= imem[IMEM_addr[9:2]];
    if (dmem_clear) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
    end else if (DMEM_wr_en) begin
      dmem[DMEM_addr[9:2]] <= DMEM_wr_data;
    end
    DMEM_rd_data <= DMEM_rst ? 32'd0 : dmem[DMEM_addr[9:2]];
  end

  typedef struct packed {
    logic [31:0] ia, da, wd;
    logic        we, rst;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic [31:0] mm [256];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int opc);
    logic [31:0] v; v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
    logic [31:0] v; v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    logic [31:0] v; v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(int imm20, int rd, int opc);
    logic [31:0] v; v = imm20;
    return {v[19:0], 5'(rd), 7'(opc)};
  endfunction
  function automatic logic [31:0] j_t(int imm, int rd);
    logic [31:0] v; v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  // One architectural step: update model state, queue the expected bus cycles
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, ij, op2, res, nxt, ea, w, nw, mask, sel;
    logic [4:0]  rd, sh;
    logic [2:0]  f3;
    logic        wr, mem, st, tk;
    exp_t        e;
    ins = imem[m_pc[9:2]];
    rd  = ins[11:7];
    f3  = ins[14:12];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = $signed(ins) >>> 20;
    is  = (ii & ~32'h1F) | {27'd0, ins[11:7]};
    ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 4;
    res = 0; wr = 0; mem = 0; st = 0; ea = 0; nw = 0;
    case (ins[6:0])
      7'h13, 7'h33: begin
        op2 = (ins[6:0] == 7'h33) ? b : ii;
        sh  = op2[4:0];
        wr  = 1;
        case (f3)
          3'd0: if (ins[5] && ins[30]) res = a - op2; else res = a + op2;
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
          3'd3: res = (a < op2) ? 32'd1 : 32'd0;
          3'd4: res = a ^ op2;
          3'd5: if (ins[30]) res = $signed(a) >>> sh; else res = a >> sh;
          3'd6: res = a | op2;
          default: res = a & op2;
        endcase
      end
      7'h37: begin wr = 1; res = {ins[31:12], 12'd0}; end
      7'h17: begin wr = 1; res = m_pc + {ins[31:12], 12'd0}; end
      7'h6F: begin wr = 1; res = m_pc + 4; nxt = m_pc + ij; end
      7'h67: begin wr = 1; res = m_pc + 4; nxt = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 0;
        endcase
        if (tk) nxt = m_pc + ib;
      end
      7'h03: begin
        mem = 1; wr = 1;
        ea  = a + ii;
        w   = mm[ea[9:2]];
        case (f3)
          3'd0: begin sel = (w >> (8 * ea[1:0])) & 32'hFF;
                      res = sel[7] ? (sel | 32'hFFFFFF00) : sel; end
          3'd1: begin sel = (w >> (16 * ea[1])) & 32'hFFFF;
                      res = sel[15] ? (sel | 32'hFFFF0000) : sel; end
          3'd4: res = (w >> (8 * ea[1:0])) & 32'hFF;
          3'd5: res = (w >> (16 * ea[1])) & 32'hFFFF;
          default: res = w;
        endcase
      end
      7'h23: begin
        mem = 1; st = 1;
        ea  = a + is;
        w   = mm[ea[9:2]];
        case (f3)
          3'd0: begin mask = 32'hFF << (8 * ea[1:0]);
                      nw = (w & ~mask) | ((b & 32'hFF) << (8 * ea[1:0])); end
          3'd1: begin mask = 32'hFFFF << (16 * ea[1]);
                      nw = (w & ~mask) | ((b & 32'hFFFF) << (16 * ea[1])); end
          default: nw = b;
        endcase
        mm[ea[9:2]] = nw;
      end
      default: ;
    endcase
    e = '{ia: m_pc, da: 32'd0, wd: 32'd0, we: 1'b0, rst: 1'b1};
    expq.push_back(e);
    expq.push_back(e);
    if (mem) begin
      e = '{ia: m_pc, da: ea & ~32'd3, wd: 32'd0, we: 1'b0, rst: 1'b0};
      expq.push_back(e);
      e = '{ia: m_pc, da: ea & ~32'd3, wd: st ? nw : 32'd0, we: st, rst: 1'b0};
      expq.push_back(e);
    end else begin
      expq.push_back(e);
    end
    if (wr && rd != 0) m_x[rd] = res;
    m_pc = nxt;
  endtask

  task automatic cmp_cycle(input exp_t e, input string tag);
    vectors++;
    if (IMEM_addr !== e.ia || DMEM_addr !== e.da || DMEM_wr_data !== e.wd ||
        DMEM_wr_en !== e.we || DMEM_rst !== e.rst) begin
      miscompares++;
      $display("FAIL %s t=%0t got ia=%h da=%h wd=%h we=%b rst=%b want ia=%h da=%h wd=%h we=%b rst=%b",
               tag, $time, IMEM_addr, DMEM_addr, DMEM_wr_data, DMEM_wr_en, DMEM_rst,
               e.ia, e.da, e.wd, e.we, e.rst);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '{ia: 32'h0, da: 32'd0, wd: 32'd0, we: 1'b0, rst: 1'b1};
    Reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      cmp_cycle(e, "reset_outputs");
    end
    @(posedge Clk);
    #2;
    Reset = 1'b0;
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic run_prog(input int n_instr, input int n_reset);
    dmem_clear = 1'b1;
    for (int i = 0; i < 256; i++) mm[i] = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc = 32'd0;
    do_reset(n_reset);
    dmem_clear = 1'b0;
    check32("if_instruction_after_reset", dut.IF_inst.IF_Instruction, 32'h0000_0013);
    for (int i = 0; i < n_instr; i++) model_step();
    while (expq.size() > 0) begin
      @(negedge Clk);
      cmp_cycle(expq.pop_front(), "bus_cycle");
    end
    @(posedge Clk);
    #2;
    for (int i = 1; i < 32; i++)
      check32($sformatf("reg_x%0d", i), dut.regs[i], m_x[i]);
  endtask

  initial begin
    // NOP cadence plus system/fence/unimp/illegal words retiring as NOP
    fill_imem();
    imem[2] = 32'h0000_0073;
    imem[3] = 32'h0FF0_000F;
    imem[4] = 32'hC000_1073;
    imem[5] = 32'hFFFF_FFFF;
    imem[6] = 32'h0010_0073;
    run_prog(7, 5);
    check32("pc_after_nops", IMEM_addr, 32'h1C);

    // ALU
    fill_imem();
    imem[0]  = i_t(5, 0, 0, 1, 7'h13);
    imem[1]  = i_t(-3, 0, 0, 2, 7'h13);
    imem[2]  = r_t(0, 2, 1, 0, 3);
    imem[3]  = r_t(32, 1, 2, 5, 4);
    imem[4]  = r_t(0, 2, 1, 3, 5);
    imem[5]  = i_t(1, 1, 0, 0, 7'h13);
    imem[6]  = r_t(32, 2, 1, 0, 6);
    imem[7]  = r_t(0, 1, 2, 2, 7);
    imem[8]  = r_t(0, 2, 1, 4, 8);
    imem[9]  = r_t(0, 2, 1, 6, 9);
    imem[10] = r_t(0, 2, 1, 7, 10);
    imem[11] = r_t(0, 1, 1, 1, 11);
    imem[12] = r_t(0, 1, 2, 5, 12);
    imem[13] = i_t(31, 1, 1, 13, 7'h13);
    imem[14] = i_t(32'h404, 13, 5, 14, 7'h13);
    imem[15] = i_t(4, 13, 5, 15, 7'h13);
    imem[16] = i_t(-2, 2, 2, 16, 7'h13);
    imem[17] = i_t(-1, 1, 3, 17, 7'h13);
    imem[18] = i_t(-1, 1, 4, 18, 7'h13);
    imem[19] = u_t(32'hFFFFF, 19, 7'h37);
    imem[20] = r_t(0, 19, 19, 0, 20);
    imem[21] = u_t(2, 21, 7'h17);
    imem[22] = i_t(32'h7FF, 0, 6, 22, 7'h13);
    imem[23] = i_t(32'h0F0, 22, 7, 23, 7'h13);
    run_prog(24, 2);
    check32("add_x3", dut.regs[3], 32'h2);
    check32("sra_x4", dut.regs[4], 32'hFFFF_FFFF);
    check32("sltu_x5", dut.regs[5], 32'h1);
    check32("srai_x14", dut.regs[14], 32'hF800_0000);
    check32("add_wrap_x20", dut.regs[20], 32'hFFFF_E000);
    check32("auipc_x21", dut.regs[21], 32'h0000_2054);
    check32("x0_write_discarded", dut.regs[0], 32'h0);

    // Loads, stores, sub-word read-modify-write
    fill_imem();
    imem[0]  = u_t(32'h80123, 1, 7'h37);
    imem[1]  = i_t(32'h456, 1, 0, 1, 7'h13);
    imem[2]  = s_t(8, 1, 0, 2);
    imem[3]  = i_t(11, 0, 0, 2, 7'h03);
    imem[4]  = i_t(11, 0, 4, 3, 7'h03);
    imem[5]  = i_t(10, 0, 1, 4, 7'h03);
    imem[6]  = i_t(32'hAB, 0, 0, 5, 7'h13);
    imem[7]  = s_t(9, 5, 0, 0);
    imem[8]  = i_t(8, 0, 2, 6, 7'h03);
    imem[9]  = i_t(10, 0, 5, 7, 7'h03);
    imem[10] = s_t(14, 5, 0, 1);
    imem[11] = i_t(12, 0, 2, 8, 7'h03);
    imem[12] = i_t(20, 0, 0, 9, 7'h13);
    imem[13] = s_t(-4, 1, 9, 2);
    imem[14] = i_t(8, 0, 0, 10, 7'h03);
    run_prog(15, 2);
    check32("lb_x2", dut.regs[2], 32'hFFFF_FF80);
    check32("lbu_x3", dut.regs[3], 32'h0000_0080);
    check32("lh_x4", dut.regs[4], 32'hFFFF_8012);
    check32("lw_after_sb_x6", dut.regs[6], 32'h8012_AB56);
    check32("sb_merge_word8", dmem[2], 32'h8012_AB56);
    check32("sh_merge_word12", dmem[3], 32'h00AB_0000);
    check32("sw_neg_offset_word16", dmem[4], 32'h8012_3456);

    // Control flow
    fill_imem();
    imem[0]  = i_t(1, 0, 0, 1, 7'h13);
    imem[1]  = i_t(1, 0, 0, 2, 7'h13);
    imem[2]  = b_t(8, 2, 1, 1);
    imem[4]  = b_t(8, 2, 1, 0);
    imem[5]  = i_t(99, 0, 0, 9, 7'h13);
    imem[6]  = j_t(32'h28, 0);
    imem[16] = j_t(32'h20, 1);
    imem[17] = i_t(-1, 0, 0, 10, 7'h13);
    imem[18] = b_t(8, 10, 1, 6);
    imem[19] = i_t(1, 0, 0, 9, 7'h13);
    imem[20] = b_t(8, 1, 10, 5);
    imem[21] = u_t(1, 12, 7'h17);
    imem[24] = i_t(1, 1, 0, 0, 7'h67);
    run_prog(12, 2);
    check32("jal_link_x1", dut.regs[1], 32'h44);
    check32("skipped_x9", dut.regs[9], 32'h0);
    check32("auipc_x12", dut.regs[12], 32'h1054);
    check32("pc_after_flow", IMEM_addr, 32'h58);

    // Reset during a store's memory cycle must suppress the write
    fill_imem();
    imem[0] = i_t(7, 0, 0, 1, 7'h13);
    imem[1] = s_t(16, 1, 0, 2);
    dmem_clear = 1'b1;
    do_reset(2);
    dmem_clear = 1'b0;
    repeat (6) @(posedge Clk);
    #2;
    check32("store_cycle_addr", DMEM_addr, 32'h10);
    check32("store_cycle_wr_en", {31'd0, DMEM_wr_en}, 32'h1);
    check32("store_cycle_data", DMEM_wr_data, 32'h7);
    Reset = 1'b1;
    #1;
    check32("wr_en_killed_by_reset", {31'd0, DMEM_wr_en}, 32'h0);
    do_reset(2);
    check32("aborted_store_word16", dmem[4], 32'h0);
    check32("regs_cleared_x1", dut.regs[1], 32'h0);
    check32("pc_restart", IMEM_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/toast_core.md
Name: toast_core

Overview:
- RV32I integer core, multi-cycle (one instruction in flight), for FPGA/simulation use.
- Fetches from an external synchronous instruction memory and loads/stores through an external synchronous data memory.
- Top of the CPU hierarchy; the memories live outside it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- IMEM_data  in  32  instruction word; memory registers IMEM[IMEM_addr] each rising edge (1-cycle latency).
- DMEM_rd_data  in  32  data word; memory registers DMEM[DMEM_addr] each rising edge (1-cycle latency), or 0 when DMEM_rst=1.
- IMEM_addr  out  32  byte address of instruction, always equal to PC.
- DMEM_addr  out  32  word-aligned byte address; bits [1:0] are always 0.
- DMEM_wr_data  out  32  full word to write.
- DMEM_wr_en  out  1  write strobe; memory writes DMEM_wr_data at DMEM_addr on the rising edge.
- DMEM_rst  out  1  clears the memory read-data register.

Behaviour:
- Reset:
  - PC=RESET_PC; x1..x31=0; state=S_FETCH; IF_Instruction=32'h0000_0013 (NOP).
  - Outputs during reset: IMEM_addr=RESET_PC, DMEM_addr=0, DMEM_wr_data=0, DMEM_wr_en=0, DMEM_rst=1.
- x0 reads 0 always; writes to x0 are discarded.
- S_FETCH: IMEM_addr=PC; the memory latches the word at the cycle's end. Next state S_DECODE.
- S_DECODE:
  - IMEM_data valid; capture it into IF_Instruction at the cycle's end.
  - IF_Instruction lives in fetch sub-module instance IF_inst (hierarchical path IF_inst.IF_Instruction) so benches can probe it.
  - Next state S_EXEC.
- S_EXEC (decode, register read, ALU):
  - OP/OP-IMM: ADD SUB AND OR XOR SLT SLTU SLL SRL SRA and immediate forms.
  - Shift amount = low 5 bits; SLT/SLTU produce 0/1; arithmetic wraps mod 2^32.
  - LUI: rd=imm<<12. AUIPC: rd=PC+(imm<<12).
  - JAL/JALR: rd=PC+4. PC=PC+immJ, or PC=(rs1+immI)&~1 for JALR.
  - Branches BEQ BNE BLT BGE BLTU BGEU: taken -> PC+=immB, else PC+=4.
  - These classes write rd and PC at the cycle's end, then go to S_FETCH. Latency is 3 cycles.
  - Load/store: EA=rs1+imm. Drive DMEM_addr=EA&~3 with DMEM_rst=0; latch EA, rs2 and funct3. Next state S_MEM.
  - FENCE, ECALL, EBREAK, SYSTEM/CSR, unimp (0xC0001073) and any illegal opcode execute as NOP (PC+=4).
- S_MEM:
  - DMEM_addr is held at the latched aligned EA; DMEM_rd_data is valid.
  - LB/LBU: lane EA[1:0]. LH/LHU: lane EA[1]. LW: ignores EA[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Write rd, PC+=4.
  - SW: DMEM_wr_data=rs2.
  - SB/SH: read-modify-write; merge rs2 low byte/half into DMEM_rd_data at the lane, other bytes unchanged.
  - Stores: DMEM_wr_en=1 for exactly this cycle; PC+=4.
  - Next state S_FETCH. Load/store latency is 4 cycles.
- DMEM_rst is 1 in every cycle except S_EXEC and S_MEM of a load/store.
- DMEM_wr_en is 0 outside S_MEM of a store.
- DMEM_addr and DMEM_wr_data are 0 when not in use.
- Reset asserted in any state aborts the instruction: no register, PC or memory write that cycle; the core restarts at S_FETCH from RESET_PC.

Decomposition:
- Shared package toast_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM);
  - funct3/funct7 constants;
  - ALU operation enum;
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM);
  - the NOP constant.
- One sub-module, toast_fetch (instance IF_inst): PC-indexed fetch and the IF_Instruction register.
- ALU and register file are inline.

Test Plan:
- Reset/fetch cadence: Reset=1 for 5 cycles -> IMEM_addr=0, DMEM_wr_en=0, DMEM_rst=1. After release, a stream of NOPs puts IMEM_addr at 0,0,0 then 4,4,4 then 8.
- ALU: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sra x4,x2,x1; sltu x5,x1,x2 -> x3=2, x4=0xFFFFFFFF, x5=1; write to x0 leaves x0=0.
- Store/load: lui x1,0x80123; addi x1,x1,0x456; sw x1,8(x0) -> one DMEM_wr_en pulse, addr 8, data 0x80123456. Then:
  - lb x2,11(x0) -> 0xFFFFFF80;
  - lbu x3,11(x0) -> 0x80;
  - lh x4,10(x0) -> 0xFFFF8012.
- Sub-word store: word 8 = 0x80123456; x5=0xAB; sb x5,9(x0) -> DMEM_wr_data=0x8012AB56 at addr 8.
- Control flow:
  - beq taken at PC 0x10 with offset +8 -> next IMEM_addr 0x18;
  - bne not taken -> PC+4;
  - jal x1,+0x20 at 0x40 -> x1=0x44, PC=0x60;
  - jalr x0,1(x1) -> PC=0x44.
- Compliance: run each riscv-tests RV32I program (add … sra, addi … srai, branches, lui, auipc, jal, jalr, loads, stores) and stop when IF_inst.IF_Instruction==0xC0001073. Pass when gp(x3)==1 and no timeout (20k cycles).
